// File: rtl/wb_burst_ram_slave_if.sv
// Wishbone B3 signal bundle between a burst-capable master and the RAM slave.
interface wb_burst_ram_slave_if #(
  parameter int unsigned aw = 32,
  parameter int unsigned dw = 32
) ();
  logic [aw-1:0]   wb_adr_i;
  logic [dw-1:0]   wb_dat_i;
  logic [dw/8-1:0] wb_sel_i;
  logic            wb_we_i;
  logic            wb_cyc_i;
  logic            wb_stb_i;
  logic [2:0]      wb_cti_i;
  logic [1:0]      wb_bte_i;
  logic [dw-1:0]   wb_dat_o;
  logic            wb_ack_o;
  logic            wb_err_o;
  logic            wb_rty_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/wb_burst_ram_slave.sv
// Wishbone B3 RAM slave with registered-feedback bursts (constant, linear, wrap-4/8/16),
// programmable wait states and out-of-range error beats.
module wb_burst_ram_slave #(
  parameter int unsigned   aw          = 32,
  parameter int unsigned   dw          = 32,
  parameter int unsigned   MEM_WORDS   = 256,
  parameter logic [aw-1:0] BASE_ADR    = '0,
  parameter int unsigned   WAIT_STATES = 0
) (
  input logic                 wb_clk_i,
  input logic                 wb_rst_i,
  wb_burst_ram_slave_if.slave wb
);

  localparam int unsigned NB    = dw / 8;
  localparam int unsigned SHIFT = (NB > 1) ? $clog2(NB) : 0;
  localparam int unsigned IW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned WCW   = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_BEAT} state_e;

  state_e           state_q;
  logic [WCW-1:0]   wcnt_q;
  logic [aw-1:0]    idx_q;
  logic             below_q;
  logic             ack_q;
  logic             err_q;
  logic [dw-1:0]    dat_q;
  logic [dw-1:0]    mem [MEM_WORDS];

  logic             cs_c;
  logic             burst_c;
  logic             hold_beat_c;
  logic [aw:0]      diff_c;
  logic             below_in_c;
  logic [aw-1:0]    idx_in_c;
  logic [aw-1:0]    idx_nxt_c;
  logic [aw-1:0]    tgt_idx_c;
  logic             tgt_below_c;
  logic             tgt_oor_c;
  logic             go_beat_c;
  logic             wr_en_c;
  logic [dw-1:0]    rd_c;

  assign cs_c        = wb.wb_cyc_i & wb.wb_stb_i;
  assign burst_c     = (wb.wb_cti_i == 3'b001) || (wb.wb_cti_i == 3'b010);
  assign hold_beat_c = (state_q == ST_BEAT) && wb.wb_cyc_i && !wb.wb_stb_i;

  // Borrow of the base subtraction flags addresses below the window.
  assign diff_c     = {1'b0, wb.wb_adr_i} - {1'b0, BASE_ADR};
  assign below_in_c = diff_c[aw];
  assign idx_in_c   = diff_c[aw-1:0] >> SHIFT;

  // Predicted index of the next burst beat; wrap modes only advance the low bits.
  always_comb begin
    idx_nxt_c = idx_q;
    if (wb.wb_cti_i == 3'b010) begin
      case (wb.wb_bte_i)
        2'b00:   idx_nxt_c      = idx_q + aw'(1);
        2'b01:   idx_nxt_c[1:0] = idx_q[1:0] + 2'd1;
        2'b10:   idx_nxt_c[2:0] = idx_q[2:0] + 3'd1;
        default: idx_nxt_c[3:0] = idx_q[3:0] + 4'd1;
      endcase
    end
  end

  // Address of the beat about to be presented and whether to enter BEAT this edge.
  always_comb begin
    tgt_idx_c   = idx_q;
    tgt_below_c = below_q;
    go_beat_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tgt_idx_c   = idx_in_c;
        tgt_below_c = below_in_c;
        go_beat_c   = cs_c && (WAIT_STATES == 0);
      end
      ST_WAIT: begin
        go_beat_c = cs_c && (wcnt_q == WCW'(WAIT_STATES - 1));
      end
      ST_BEAT: begin
        tgt_idx_c   = idx_nxt_c;
        tgt_below_c = 1'b0;
        go_beat_c   = cs_c && !err_q && burst_c && (WAIT_STATES == 0);
      end
      default: ;
    endcase
    tgt_oor_c = tgt_below_c || (tgt_idx_c >= aw'(MEM_WORDS));
  end

  assign rd_c    = mem[tgt_idx_c[IW-1:0]];
  assign wr_en_c = !wb_rst_i && (state_q == ST_BEAT) && cs_c && ack_q && wb.wb_we_i;

  // Beat sequencer: ack/err/read data are all registered on the edge entering BEAT.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      idx_q   <= '0;
      below_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      if (go_beat_c) begin
        ack_q   <= !tgt_oor_c;
        err_q   <= tgt_oor_c;
        dat_q   <= rd_c;
        idx_q   <= tgt_idx_c;
        below_q <= tgt_below_c;
      end else if (!hold_beat_c) begin
        ack_q <= 1'b0;
        err_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (cs_c) begin
            idx_q   <= idx_in_c;
            below_q <= below_in_c;
            wcnt_q  <= '0;
            state_q <= (WAIT_STATES == 0) ? ST_BEAT : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!wb.wb_cyc_i) begin
            state_q <= ST_IDLE;
          end else if (wb.wb_stb_i) begin
            if (go_beat_c) begin
              state_q <= ST_BEAT;
              wcnt_q  <= '0;
            end else begin
              wcnt_q <= wcnt_q + WCW'(1);
            end
          end
        end
        ST_BEAT: begin
          if (!wb.wb_cyc_i) begin
            state_q <= ST_IDLE;
          end else if (wb.wb_stb_i) begin
            if (err_q || !burst_c) begin
              state_q <= ST_IDLE;
            end else if (WAIT_STATES != 0) begin
              state_q <= ST_WAIT;
              idx_q   <= idx_nxt_c;
              below_q <= 1'b0;
              wcnt_q  <= '0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Byte-lane write at the end of an acknowledged write beat; contents survive reset.
  always_ff @(posedge wb_clk_i) begin
    if (wr_en_c) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (wb.wb_sel_i[b]) mem[idx_q[IW-1:0]][8*b +: 8] <= wb.wb_dat_i[8*b +: 8];
      end
    end
  end

  assign wb.wb_dat_o = dat_q;
  assign wb.wb_ack_o = ack_q & wb.wb_cyc_i & wb.wb_stb_i;
  assign wb.wb_err_o = err_q & wb.wb_cyc_i & wb.wb_stb_i;
  assign wb.wb_rty_o = 1'b0;

endmodule

// File: doc/wb_burst_ram_slave.md
Name: wb_burst_ram_slave

Overview:
- Synthesisable Wishbone B3 slave memory with registered-feedback burst support.
- Sits directly downstream of the randomised Wishbone master/transactor and is the target that consumes its classic, constant-address and incrementing bursts (linear, wrap-4/8/16).
- Provides configurable wait states and out-of-range error signalling, so master-side bursts, wait-state handling and data integrity can be checked against real RTL.

Parameters:
aw, 32, address width
dw, 32, data width; multiple of 8
MEM_WORDS, 256, memory depth in dw-bit words
BASE_ADR, 0, byte address of word 0
WAIT_STATES, 0, idle cycles inserted before every beat's ack/err (0..15)

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
wb_adr_i  in  aw  byte address
wb_dat_i  in  dw  write data
wb_sel_i  in  dw/8  byte lane enables
wb_we_i  in  1  1=write
wb_cyc_i  in  1  cycle valid
wb_stb_i  in  1  strobe
wb_cti_i  in  3  cycle type identifier
wb_bte_i  in  2  burst type extension
wb_dat_o  out  dw  read data, valid while wb_ack_o high
wb_ack_o  out  1  beat acknowledge
wb_err_o  out  1  beat error
wb_rty_o  out  1  constant 0

Behaviour:
- Reset:
  - On a clock edge with wb_rst_i high: FSM to IDLE, wait counter 0, ack/err registers 0, wb_dat_o 0.
  - Memory contents are not cleared.
  - Reset mid-burst aborts the burst with no further writes. wb_ack_o/wb_err_o are low from the cycle after the reset edge.
- Address handling:
  - Word index = (adr - BASE_ADR) >> log2(dw/8); unused low address bits are ignored.
  - A beat is out of range if adr < BASE_ADR or index >= MEM_WORDS.
- Output gating: wb_ack_o = ack_reg & wb_cyc_i & wb_stb_i. wb_err_o is gated the same way.
- FSM states: IDLE, WAIT, BEAT.
  - IDLE: on cyc&stb, latch the beat address from wb_adr_i. Go to WAIT if WAIT_STATES>0, else go to BEAT with ack_reg (or err_reg if out of range) set.
  - WAIT: counts WAIT_STATES cycles with stb high; the count holds while stb is low. When it expires, enter BEAT asserting ack or err.
  - BEAT: ack (or err) is high for this cycle.
- Beat completion at the end of a BEAT cycle, qualified by cyc&stb:
  - Write: memory[index] byte lanes with wb_sel_i set take wb_dat_i.
  - Read: wb_dat_o was loaded from memory[index] on the edge entering BEAT.
- Next state after BEAT:
  - Classic (cti 000, reserved 011-110) or cti 111: go to IDLE. The next access is sampled no earlier than the following cycle, so a classic beat takes 2+WAIT_STATES cycles.
  - cti 001 (constant): the next address equals the current address.
  - cti 010 (incrementing): the next word index is +1 for bte 00 (linear). For bte 01/10/11 only the low 2/3/4 index bits increment, modulo 4/8/16, and the upper bits are held.
  - For 001/010 with WAIT_STATES=0: stay in BEAT with ack asserted on consecutive cycles using the internally predicted address.
  - For 001/010 with WAIT_STATES>0: return to WAIT between beats.
- Burst stall and abort:
  - stb low in a burst: no ack/write/advance; the state is held. Beats resume when stb returns.
  - cyc low at any time: go to IDLE next cycle with no write.
- Error handling:
  - An out-of-range beat gives a one-cycle err instead of ack; there is no write and read data is don't-care.
  - The FSM returns to IDLE, terminating any burst.
  - An in-range burst that walks out of range errors on the first offending beat only.
- Simultaneous events:
  - reset beats everything.
  - cyc low beats a pending ack.
  - cti 111 in a BEAT cycle ends the burst after that beat's ack.

Test Plan:
- Classic write 0x10 data 0xDEADBEEF sel 4'hF, then classic read 0x10 -> ack exactly 1 cycle after stb is first sampled, wb_dat_o=0xDEADBEEF, ack low the cycle after.
- Write 0x10 sel 4'b0010 data 0x0000AA00 after the above, then read 0x10 -> 0xDEADAAEF.
- Linear incrementing write 8 beats from 0x40 (data 1..8, last beat cti 111), then 8-beat linear read -> 8 consecutive acks each, read data 1..8, ack low after the cti 111 beat.
- Wrap-4 read burst of 4 beats from 0x1C, memory preloaded with word index -> internal addresses 0x1C,0x10,0x14,0x18, data 7,4,5,6 on 4 consecutive ack cycles.
- Out of range, part 1: classic read 0x400 -> one err pulse, no ack.
- Out of range, part 2: linear burst from 0x3F8 -> ack, ack, err on beat 3, FSM back to IDLE.
- WAIT_STATES=2 build: classic read latency 3 cycles; 4-beat burst acks every 3rd cycle; stb dropped 2 cycles mid-burst adds exactly 2 cycles; wb_rst_i pulsed mid-burst -> ack low next cycle, earlier-written words unchanged on readback.
